conv_encoder: RTL

- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder: its trellis (4 states, generators 7/5 octal) is the one the decoder's path-metric selector resolves.
- Accepts one information bit per handshake and emits one 2-bit coded symbol per handshake.
- Each frame is terminated with K-1 zero tail bits, so the decoder always starts and ends in state 0.

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/conv_sym_gen.sv | 21 ++
 rtl/conv_encoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2, K=3 convolutional code (generators 7/5 octal).
// Both the transmit encoder and the decoder's branch-metric unit build on these constants.
package viterbi_pkg;

   localparam int K       = 3;
   localparam int NSTATES = 1 << (K - 1);
   localparam int SYM_W   = 2;
   localparam int STATE_W = K - 1;

   // Bit K-1 of each generator taps the current input bit.
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   typedef enum logic [1:0] {
      ENC_IDLE = 2'd0,
      ENC_DATA = 2'd1,
      ENC_TAIL = 2'd2
   } enc_fsm_e;

endpackage

// File: rtl/conv_sym_gen.sv
// One trellis branch: maps {input bit, state} to the coded symbol and the successor state.
// Purely combinational; no handshake of its own.
module conv_sym_gen #(
   parameter int           K  = viterbi_pkg::K,
   parameter logic [K-1:0] G0 = viterbi_pkg::G0,
   parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
   input  logic                            u_i,
   input  logic [K-2:0]                    state_i,
   output logic [viterbi_pkg::SYM_W-1:0]   sym_o,
   output logic [K-2:0]                    next_state_o
);
   import viterbi_pkg::*;

   logic [K-1:0] win;

   assign win          = {u_i, state_i};
   assign sym_o        = {^(win & G0), ^(win & G1)};
   assign next_state_o = win[K-1:1];

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with zero-tail termination; 1-cycle latency, one registered output slot.
// Backpressure: the slot holds while out_valid && !out_ready, stalling input and tail generation.
module conv_encoder #(
   parameter int           K       = viterbi_pkg::K,
   parameter logic [K-1:0] G0      = viterbi_pkg::G0,
   parameter logic [K-1:0] G1      = viterbi_pkg::G1,
   parameter bit           TAIL_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_bit,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   out_sym,
   output logic         out_last,
   output logic [K-2:0] enc_state
);
   import viterbi_pkg::*;

   localparam logic [1:0] TAIL_LAST = 2'(K - 2);

   enc_fsm_e     fsm_q, fsm_d;
   logic [K-2:0] state_q, state_d;
   logic [1:0]   tail_cnt_q, tail_cnt_d;
   logic         out_valid_q, out_valid_d;
   logic [1:0]   out_sym_q, out_sym_d;
   logic         out_last_q, out_last_d;

   logic         slot_free;
   logic         accept;
   logic         tail_load;
   logic         gen_u;
   logic [1:0]   gen_sym;
   logic [K-2:0] gen_next;

   assign slot_free = !out_valid_q || out_ready;
   // Gated by rst_n so the upstream never sees a ready while reset is held.
   assign in_ready  = rst_n && (fsm_q != ENC_TAIL) && slot_free;
   assign accept    = in_valid && in_ready;
   assign tail_load = (fsm_q == ENC_TAIL) && slot_free;
   assign gen_u     = (fsm_q == ENC_TAIL) ? 1'b0 : in_bit;

   conv_sym_gen #(
      .K  (K),
      .G0 (G0),
      .G1 (G1)
   ) u_sym_gen (
      .u_i          (gen_u),
      .state_i      (state_q),
      .sym_o        (gen_sym),
      .next_state_o (gen_next)
   );

   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      tail_cnt_d  = tail_cnt_q;
      out_valid_d = out_valid_q && !out_ready;
      out_sym_d   = out_sym_q;
      out_last_d  = out_last_q;

      if (accept || tail_load) begin
         out_valid_d = 1'b1;
         out_sym_d   = gen_sym;
         out_last_d  = 1'b0;
         state_d     = gen_next;
      end

      case (fsm_q)
         ENC_IDLE, ENC_DATA: begin
            if (accept) begin
               if (!in_last) begin
                  fsm_d = ENC_DATA;
               end else if (TAIL_EN) begin
                  fsm_d      = ENC_TAIL;
                  tail_cnt_d = '0;
               end else begin
                  // Truncated frame: forget history so the next frame starts in state 0.
                  fsm_d      = ENC_IDLE;
                  out_last_d = 1'b1;
                  state_d    = '0;
               end
            end
         end
         ENC_TAIL: begin
            if (tail_load) begin
               if (tail_cnt_q == TAIL_LAST) begin
                  fsm_d      = ENC_IDLE;
                  tail_cnt_d = '0;
                  out_last_d = 1'b1;
               end else begin
                  tail_cnt_d = tail_cnt_q + 2'd1;
               end
            end
         end
         default: begin
            fsm_d = ENC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= ENC_IDLE;
         state_q     <= '0;
         tail_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_sym_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         tail_cnt_q  <= tail_cnt_d;
         out_valid_q <= out_valid_d;
         out_sym_q   <= out_sym_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_last  = out_last_q;
   assign enc_state = state_q;

endmodule
